// File: rtl/cpu_memsys_if.sv
// Memory-port and console-stream bundle between the 16-bit CPU, cpu_memsys and the console sink.
interface cpu_memsys_if;
  logic [15:0] mem_raddr_i;
  logic        mem_rd_i;
  logic [15:0] mem_rdata_o;
  logic [15:0] mem_waddr_i;
  logic [15:0] mem_wdata_i;
  logic        mem_wr_i;
  logic [7:0]  con_data_o;
  logic        con_valid_o;
  logic        con_ready_i;

  modport slave (
    input  mem_raddr_i, mem_rd_i, mem_waddr_i, mem_wdata_i, mem_wr_i, con_ready_i,
    output mem_rdata_o, con_data_o, con_valid_o
  );

  modport master (
    output mem_raddr_i, mem_rd_i, mem_waddr_i, mem_wdata_i, mem_wr_i, con_ready_i,
    input  mem_rdata_o, con_data_o, con_valid_o
  );
endinterface

// File: rtl/cpu_memsys.sv
// Memory responder for the CPU: synchronous RAM, console byte FIFO, status register and
// a 32-bit cycle counter with a coherent high-word snapshot.
module cpu_memsys #(
  parameter int RAM_AWIDTH = 12,
  parameter int FIFO_LOG2  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  cpu_memsys_if.slave  bus
);
  localparam int               RAM_DEPTH  = 1 << RAM_AWIDTH;
  localparam int               FIFO_DEPTH = 1 << FIFO_LOG2;
  localparam logic [16:0]      RAM_WORDS  = 17'(1) << RAM_AWIDTH;
  localparam logic [FIFO_LOG2:0] CNT_FULL = (FIFO_LOG2+1)'(FIFO_DEPTH);
  localparam logic [FIFO_LOG2:0] CNT_ONE  = (FIFO_LOG2+1)'(1);
  localparam logic [15:0]      A_CON_DATA = 16'hFFF0;
  localparam logic [15:0]      A_CON_STAT = 16'hFFF1;
  localparam logic [15:0]      A_CYC_LO   = 16'hFFF2;
  localparam logic [15:0]      A_CYC_HI   = 16'hFFF3;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_IO   = 2'd2
  } sel_e;

  logic [15:0]          ram_mem [0:RAM_DEPTH-1];
  logic [15:0]          ram_dout_q;
  logic [7:0]           fifo_mem [0:FIFO_DEPTH-1];

  sel_e                 sel_q, sel_d;
  logic [15:0]          io_q, io_d;
  logic [15:0]          snap_q, snap_d;
  logic [31:0]          cyc_q, cyc_d;
  logic [FIFO_LOG2-1:0] wptr_q, wptr_d, rptr_q, rptr_d, rptr_nx;
  logic [FIFO_LOG2:0]   cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [7:0]           head_q, head_d;

  logic        rd_in_ram, wr_in_ram, ram_we;
  logic        push, push_ok, pop, ovf_clr, fifo_full, fifo_empty;
  logic [7:0]  wbyte;
  logic [15:0] stat_word;
  logic        unused_wdata;

  // Address decode: RAM is the low window only, so anything above it is not an alias.
  assign rd_in_ram  = {1'b0, bus.mem_raddr_i} < RAM_WORDS;
  assign wr_in_ram  = {1'b0, bus.mem_waddr_i} < RAM_WORDS;
  assign ram_we     = bus.mem_wr_i & wr_in_ram;
  assign wbyte      = bus.mem_wdata_i[7:0];
  assign push       = bus.mem_wr_i & ~wr_in_ram & (bus.mem_waddr_i == A_CON_DATA);
  assign ovf_clr    = bus.mem_wr_i & ~wr_in_ram & (bus.mem_waddr_i == A_CON_STAT)
                      & bus.mem_wdata_i[2];
  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CNT_FULL);
  assign pop        = ~fifo_empty & bus.con_ready_i;
  assign push_ok    = push & (~fifo_full | pop);
  assign rptr_nx    = rptr_q + 1'b1;
  assign stat_word  = {8'(cnt_q), 5'b0, ovf_q, fifo_full, fifo_empty};
  assign unused_wdata = ^bus.mem_wdata_i[15:8];

  // Read-first RAM: the read register sees the word as it was before this edge's write.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_mem[bus.mem_waddr_i[RAM_AWIDTH-1:0]] <= bus.mem_wdata_i;
    end
    if (bus.mem_rd_i) begin
      ram_dout_q <= ram_mem[bus.mem_raddr_i[RAM_AWIDTH-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wptr_q] <= wbyte;
    end
  end

  always_comb begin
    sel_d  = sel_q;
    io_d   = io_q;
    snap_d = snap_q;
    if (bus.mem_rd_i) begin
      if (rd_in_ram) begin
        sel_d = SEL_RAM;
      end else begin
        sel_d = SEL_NONE;
        io_d  = 16'h0000;
        case (bus.mem_raddr_i)
          A_CON_STAT: begin
            sel_d = SEL_IO;
            io_d  = stat_word;
          end
          A_CYC_LO: begin
            sel_d  = SEL_IO;
            io_d   = cyc_q[15:0];
            snap_d = cyc_q[31:16];
          end
          A_CYC_HI: begin
            sel_d = SEL_IO;
            io_d  = snap_q;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    cyc_d  = cyc_q + 32'd1;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    head_d = head_q;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop)     rptr_d = rptr_nx;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    // A dropped push outranks a same-cycle software clear.
    if (push & fifo_full & ~pop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    // The head register only moves on a pop, or when the first byte lands in an empty FIFO.
    if (pop) begin
      if (cnt_q > CNT_ONE) begin
        head_d = fifo_mem[rptr_nx];
      end else if (push_ok) begin
        head_d = wbyte;
      end
    end else if (push_ok && fifo_empty) begin
      head_d = wbyte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= SEL_NONE;
      io_q   <= 16'h0000;
      snap_q <= 16'h0000;
      cyc_q  <= 32'h0000_0000;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      head_q <= 8'h00;
    end else begin
      sel_q  <= sel_d;
      io_q   <= io_d;
      snap_q <= snap_d;
      cyc_q  <= cyc_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      head_q <= head_d;
    end
  end

  assign bus.mem_rdata_o = (sel_q == SEL_RAM) ? ram_dout_q :
                           (sel_q == SEL_IO)  ? io_q       : 16'h0000;
  assign bus.con_data_o  = head_q;
  assign bus.con_valid_o = ~fifo_empty;
endmodule

// File: tb/tb_cpu_memsys.sv
// Directed vector bench for cpu_memsys: RAM, console FIFO, status, cycle counter and async reset.
module tb_cpu_memsys;
  logic clk;
  logic rst_n;
  cpu_memsys_if bus();

  cpu_memsys #(.RAM_AWIDTH(12), .FIFO_LOG2(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference cycle count: value the counter holds going into the next edge.
  logic [31:0] tb_cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= 32'd0;
    else        tb_cyc <= tb_cyc + 32'd1;
  end

  typedef struct {
    string       name;
    logic        rd;
    logic [15:0] ra;
    logic        wr;
    logic [15:0] wa;
    logic [15:0] wd;
    logic        rdy;
    logic        chk_rd;
    logic [15:0] exp_rd;
    logic        exp_v;
    logic [7:0]  exp_cd;
  } vec_t;

  int n_vec = 0;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(string nm, logic rd, logic [15:0] ra, logic wr, logic [15:0] wa,
                              logic [15:0] wd, logic rdy, logic chk_rd, logic [15:0] exp_rd,
                              logic exp_v, logic [7:0] exp_cd);
    vec_t v;
    v.name = nm; v.rd = rd; v.ra = ra; v.wr = wr; v.wa = wa; v.wd = wd; v.rdy = rdy;
    v.chk_rd = chk_rd; v.exp_rd = exp_rd; v.exp_v = exp_v; v.exp_cd = exp_cd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.mem_rd_i    = v.rd;
    bus.mem_raddr_i = v.ra;
    bus.mem_wr_i    = v.wr;
    bus.mem_waddr_i = v.wa;
    bus.mem_wdata_i = v.wd;
    bus.con_ready_i = v.rdy;
  endtask

  task automatic apply_vec(input vec_t v);
    drive(v);
    @(posedge clk);
    #1;
    n_vec++;
    $display("vec %0d %s: rdata=%h valid=%b con_data=%h", n_vec, v.name,
             bus.mem_rdata_o, bus.con_valid_o, bus.con_data_o);
    if (v.chk_rd) chk({v.name, " rdata"}, 32'(bus.mem_rdata_o), 32'(v.exp_rd));
    chk({v.name, " valid"}, 32'(bus.con_valid_o), 32'(v.exp_v));
    if (v.exp_v) chk({v.name, " con_data"}, 32'(bus.con_data_o), 32'(v.exp_cd));
  endtask

  task automatic idle();
    drive(mk("idle", 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 8'h0));
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [17];
  logic [7:0] drain_q [16];
  int guard;

  initial begin
    tbl[0]  = mk("ram_wr_unm_rd", 1, 16'h2000, 1, 16'h0010, 16'h1234, 0, 1, 16'h0000, 0, 8'h00);
    tbl[1]  = mk("ram_roundtrip", 1, 16'h0010, 0, 16'h0000, 16'h0000, 0, 1, 16'h1234, 0, 8'h00);
    tbl[2]  = mk("ram_read_first", 1, 16'h0010, 1, 16'h0010, 16'h5678, 0, 1, 16'h1234, 0, 8'h00);
    tbl[3]  = mk("ram_new_data",  1, 16'h0010, 0, 16'h0000, 16'h0000, 0, 1, 16'h5678, 0, 8'h00);
    tbl[4]  = mk("ram_wr_zero",   1, 16'h2000, 1, 16'h0000, 16'hBEEF, 0, 1, 16'h0000, 0, 8'h00);
    tbl[5]  = mk("alias_wr",      1, 16'h0000, 1, 16'h1000, 16'hDEAD, 0, 1, 16'hBEEF, 0, 8'h00);
    tbl[6]  = mk("unmapped_rd",   1, 16'h1000, 0, 16'h0000, 16'h0000, 0, 1, 16'h0000, 0, 8'h00);
    tbl[7]  = mk("alias_rd",      1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1, 16'hBEEF, 0, 8'h00);
    tbl[8]  = mk("rdata_hold",    0, 16'h0010, 0, 16'h0000, 16'h0000, 0, 1, 16'hBEEF, 0, 8'h00);
    tbl[9]  = mk("push41",        1, 16'hFFF1, 1, 16'hFFF0, 16'h0141, 0, 1, 16'h0001, 1, 8'h41);
    tbl[10] = mk("push42",        1, 16'hFFF0, 1, 16'hFFF0, 16'h0042, 0, 1, 16'h0000, 1, 8'h41);
    tbl[11] = mk("push43",        1, 16'hFFF1, 1, 16'hFFF0, 16'h0043, 0, 1, 16'h0200, 1, 8'h41);
    tbl[12] = mk("stat_three",    1, 16'hFFF1, 0, 16'h0000, 16'h0000, 0, 1, 16'h0300, 1, 8'h41);
    tbl[13] = mk("pop41",         1, 16'hFFF1, 0, 16'h0000, 16'h0000, 1, 1, 16'h0300, 1, 8'h42);
    tbl[14] = mk("pop42",         0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 1, 16'h0300, 1, 8'h43);
    tbl[15] = mk("pop43",         0, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 0, 8'h00);
    tbl[16] = mk("stat_empty",    1, 16'hFFF1, 0, 16'h0000, 16'h0000, 0, 1, 16'h0001, 0, 8'h00);

    for (int i = 0; i < 15; i++) drain_q[i] = 8'h51 + 8'(i);
    drain_q[15] = 8'h70;

    rst_n = 1'b0;
    drive(mk("init", 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0, 8'h0));
    #12;
    chk("reset rdata", 32'(bus.mem_rdata_o), 32'h0);
    chk("reset valid", 32'(bus.con_valid_o), 32'h0);
    chk("reset con_data", 32'(bus.con_data_o), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 17; i++) apply_vec(tbl[i]);

    // Fill to full, then one more push that must be dropped and flag overflow.
    for (int i = 0; i < 17; i++)
      apply_vec(mk($sformatf("fill%0d", i), 0, 16'h0, 1, 16'hFFF0, 16'h0050 + 16'(i), 0,
                   0, 16'h0, 1, 8'h50));
    apply_vec(mk("stat_full_ovf", 1, 16'hFFF1, 0, 16'h0, 16'h0, 0, 1, 16'h1006, 1, 8'h50));
    apply_vec(mk("push_pop_full", 1, 16'hFFF1, 1, 16'hFFF0, 16'h0070, 1, 1, 16'h1006, 1, 8'h51));
    apply_vec(mk("stat_still16",  1, 16'hFFF1, 0, 16'h0, 16'h0, 0, 1, 16'h1006, 1, 8'h51));
    apply_vec(mk("ovf_clear",     1, 16'hFFF1, 1, 16'hFFF1, 16'h0004, 0, 1, 16'h1006, 1, 8'h51));
    apply_vec(mk("stat_cleared",  1, 16'hFFF1, 0, 16'h0, 16'h0, 0, 1, 16'h1002, 1, 8'h51));
    for (int i = 0; i < 16; i++)
      apply_vec(mk($sformatf("drain%0d", i), 0, 16'h0, 0, 16'h0, 16'h0, 1, 0, 16'h0,
                   (i < 15) ? 1'b1 : 1'b0, (i < 15) ? drain_q[i+1] : 8'h00));
    apply_vec(mk("stat_drained",  1, 16'hFFF1, 0, 16'h0, 16'h0, 0, 1, 16'h0001, 0, 8'h00));

    // Async reset with bytes queued and a read being driven.
    apply_vec(mk("pre_rst_wr", 0, 16'h0, 1, 16'h0020, 16'hCAFE, 0, 0, 16'h0, 0, 8'h00));
    for (int i = 0; i < 5; i++)
      apply_vec(mk($sformatf("pre_rst_push%0d", i), 0, 16'h0, 1, 16'hFFF0, 16'h0061 + 16'(i), 0,
                   0, 16'h0, 1, 8'h61));
    apply_vec(mk("pre_rst_rd", 1, 16'h0020, 0, 16'h0, 16'h0, 0, 1, 16'hCAFE, 1, 8'h61));
    drive(mk("rd_pending", 1, 16'h0020, 0, 16'h0, 16'h0, 0, 0, 16'h0, 0, 8'h0));
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst rdata", 32'(bus.mem_rdata_o), 32'h0);
    chk("async_rst valid", 32'(bus.con_valid_o), 32'h0);
    chk("async_rst con_data", 32'(bus.con_data_o), 32'h0);
    #2;
    rst_n = 1'b1;
    apply_vec(mk("post_rst_rd",   1, 16'h0020, 0, 16'h0, 16'h0, 0, 1, 16'hCAFE, 0, 8'h00));
    apply_vec(mk("post_rst_stat", 1, 16'hFFF1, 0, 16'h0, 16'h0, 0, 1, 16'h0001, 0, 8'h00));

    // Run the counter up to the 16-bit boundary and check the snapshot pairing.
    guard = 0;
    while (tb_cyc != 32'h0000FFFF && guard < 70000) begin
      idle();
      guard++;
    end
    chk("cyc_wait", tb_cyc, 32'h0000FFFF);
    apply_vec(mk("cyc_lo_ffff", 1, 16'hFFF2, 0, 16'h0, 16'h0, 0, 1, 16'hFFFF, 0, 8'h00));
    apply_vec(mk("cyc_hi_snap", 1, 16'hFFF3, 0, 16'h0, 16'h0, 0, 1, 16'h0000, 0, 8'h00));
    apply_vec(mk("cyc_lo_wrap", 1, 16'hFFF2, 0, 16'h0, 16'h0, 0, 1, 16'h0001, 0, 8'h00));
    apply_vec(mk("cyc_hi_one",  1, 16'hFFF3, 0, 16'h0, 16'h0, 0, 1, 16'h0001, 0, 8'h00));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/cpu_memsys.md
# cpu_memsys

Memory-side responder for the 16-bit CPU's split read/write memory port. It sits directly on the CPU's `mem_*` signals and serves instruction fetches, loads and stores. It holds a synchronous single-clock RAM plus a small I/O page: a console output FIFO with a valid/ready byte stream, a status register, and a 32-bit free-running cycle counter.

## Interface
Parameters:
- `RAM_AWIDTH`, default 12: RAM word-address width. The RAM has 2^RAM_AWIDTH 16-bit words at addresses 0 .. 2^RAM_AWIDTH-1.
- `FIFO_LOG2`, default 4: the console FIFO holds 2^FIFO_LOG2 bytes.

Ports:
- `clk` in, 1: the only clock.
- `rst_n` in, 1: reset, asynchronous, active-low.
- `mem_raddr_i` in, 16: read word address.
- `mem_rd_i` in, 1: read request.
- `mem_rdata_o` out, 16: read data.
- `mem_waddr_i` in, 16: write word address.
- `mem_wdata_i` in, 16: write data.
- `mem_wr_i` in, 1: write strobe.
- `con_data_o` out, 8: console byte, which is the FIFO head.
- `con_valid_o` out, 1: the FIFO is non-empty.
- `con_ready_i` in, 1: the downstream sink accepts the byte.

## Operation
Address map. It is decoded identically for reads and writes:
- 0 .. 2^RAM_AWIDTH-1: RAM.
- 0xFFF0 CON_DATA:
  - Write pushes `mem_wdata_i[7:0]`.
  - Read returns 0.
- 0xFFF1 CON_STAT:
  - Read returns {count[7:0], 5'b0, ovf, full, empty}, where count is zero-extended FIFO occupancy.
  - Write with `mem_wdata_i[2]`=1 clears ovf. Other bits are ignored.
- 0xFFF2 CYC_LO:
  - Read returns cycle[15:0].
  - The same read copies cycle[31:16] into a snapshot register.
- 0xFFF3 CYC_HI: read returns the snapshot register.
- Everything else: reads return 0x0000 and writes are ignored. RAM does not alias.

Behaviour:
- RAM:
  - Single write port and single read port.
  - A write lands at the clock edge where `mem_wr_i`=1.
  - Same-address read and write in the same cycle is read-first: the read returns the old data.
  - RAM contents are not reset.
- Console FIFO:
  - Circular buffer with read and write pointers that wrap at 2^FIFO_LOG2, plus an occupancy count of FIFO_LOG2+1 bits.
  - Pop happens when `con_valid_o` & `con_ready_i` are both 1.
  - A push is accepted if the FIFO is not full, or if a pop happens in the same cycle.
  - A push to a full FIFO with no simultaneous pop is dropped and sets the sticky ovf bit.
  - A push that sets ovf and a CON_STAT clear in the same cycle: set wins.
- Cycle counter:
  - 32 bits, increments every cycle after reset, wraps from 0xFFFFFFFF to 0.
  - The value reported by a CYC_LO read is the counter value at the edge that samples the request.
- Stores and loads may target the I/O page in the same cycle. Both take effect independently.

## Timing
- Read latency is exactly 1 cycle:
  - The address is sampled at edge N when `mem_rd_i`=1.
  - `mem_rdata_o` holds the data from edge N until the next sampled read.
  - When `mem_rd_i`=0, `mem_rdata_o` holds its previous value.
  - This is required because the CPU drives `mem_rd_i`=1 permanently and latches `mem_rdata_i` the cycle after issuing the address.
- The region select is registered alongside the read address. The output mux uses only registered state and the RAM output register. No combinational path from `mem_raddr_i` to `mem_rdata_o`.
- Read-side effects happen at the sampling edge: a CYC_LO read captures the snapshot there.
- A write is visible to a read sampled at edge N+1 or later.
- FIFO push and pop happen at the same edge as the request. `con_valid_o` rises in the cycle after the first push into an empty FIFO. `con_data_o` changes only on a pop or on a push into an empty FIFO.
- Reset (asynchronous assert, synchronous to `clk` in effect on release) sets:
  - `mem_rdata_o`=0x0000, `con_valid_o`=0, `con_data_o`=0x00.
  - Pointers=0, count=0, ovf=0, cycle=0, snapshot=0.
  - Registered read address/select = unmapped.
- Reset mid-operation discards FIFO contents and any read in flight. The first read sampled after release returns valid data one cycle later.

## Test plan
- RAM round trip: write 0x1234 to 0x0010, then read 0x0010 on the next cycle. `mem_rdata_o`=0x1234 exactly one cycle after the read is sampled. A simultaneous write of 0x5678 to 0x0010 with a read of 0x0010 returns 0x1234, and a read on the following cycle returns 0x5678.
- Unmapped and alias check: with RAM_AWIDTH=12, a write to 0x1000 followed by reads of 0x1000 and 0x0000 returns 0x0000 and the unchanged RAM word respectively.
- Console stream: with `con_ready_i`=0, push 0x41,0x42,0x43. CON_STAT reads 0x0300. Then raise ready: bytes 0x41,0x42,0x43 come out in order on consecutive cycles, `con_valid_o` drops after the third, and CON_STAT reads 0x0001.
- FIFO full, overflow and wrap:
  - Push 17 bytes with ready=0. The 17th is dropped and CON_STAT reads 0x1006.
  - A push while full together with a pop is accepted and count stays 16.
  - Writing 0x0004 to CON_STAT clears ovf.
  - Draining the FIFO yields all 16 bytes in order across the pointer wrap.
- Cycle counter: force the counter near 0x0000FFFF, read CYC_LO then CYC_HI. The pair is consistent: the high word comes from the snapshot even when the low word has since wrapped.
- Async reset mid-stream: assert `rst_n`=0 with 5 bytes queued and a read pending. All outputs go to their reset values without a clock edge. After release, RAM data written before reset is still readable.
